// File: rtl/snoop_cmd_queue.sv
// Snoop command queue: buffers foreign system-bus commands for the CPU snoop port.
// Define SNOOP_TIMEOUT_EN to add the CPU ack timeout (forced miss + timeout_err).
module snoop_cmd_queue #(
    parameter int DEPTH      = 8,
    parameter int MY_DEV_ID  = 0,
    parameter int HOLD_LEVEL = 6,
    parameter int TIMEOUT    = 64
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [3:0]  sys_command,
    input  logic [39:0] sys_address,
    input  logic [2:0]  sys_dev_id,
    input  logic [2:0]  sys_cmd_id,
    output logic [3:0]  cpu_command,
    output logic [39:0] cpu_address,
    output logic        cpu_sys_valid,
    input  logic [2:0]  cpu_ack,
    output logic        shared_out,
    output logic        owned_out,
    output logic        resp_valid,
    output logic [2:0]  resp_dev_id,
    output logic [2:0]  resp_cmd_id,
    output logic        sys_hold_out,
    output logic        overflow,
    output logic        timeout_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 50;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_LEVEL);
    localparam logic [2:0]    MY_ID  = 3'(MY_DEV_ID);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          nonempty_q;

    logic [3:0]  cmd_q, cmd_d;
    logic [39:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic        shared_q, shared_d;
    logic        owned_q, owned_d;
    logic        rvalid_q, rvalid_d;
    logic [2:0]  rdev_q, rdev_d;
    logic [2:0]  rcid_q, rcid_d;
    logic        hold_q;
    logic        ovf_q, ovf_d;

    logic [EW-1:0] head;
    logic          push_req;
    logic          full;
    logic          ack_hit;
    logic          tmo_hit;
    logic          pop;
    logic          push;

    assign head     = mem_q[rd_ptr_q];
    assign full     = (count_q == FULL_C);
    assign push_req = (sys_command != 4'd0) && (sys_dev_id != MY_ID);
    assign ack_hit  = (state_q == PRESENT) && (cpu_ack != 3'd0);
    assign pop      = ack_hit || tmo_hit;
    // A full queue still accepts when the head leaves on the same edge
    assign push     = push_req && (!full || pop);

`ifdef SNOOP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          tmo_err_q;

    assign tmo_hit = (state_q == PRESENT) && (cpu_ack == 3'd0)
                     && (tmr_q == TMO_LAST);

    always_comb begin
        tmr_d = '0;
        if (state_q == PRESENT) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            tmr_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            tmo_err_q <= tmo_err_q | tmo_hit;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    // TIMEOUT is only meaningful in the timeout build
    assign tmo_hit     = (TIMEOUT < 0);
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        shared_d = 1'b0;
        owned_d  = 1'b0;
        rvalid_d = 1'b0;
        rdev_d   = 3'd0;
        rcid_d   = 3'd0;
        ovf_d    = ovf_q | (push_req && full && !pop);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (nonempty_q) begin
                    state_d = PRESENT;
                    cmd_d   = head[49:46];
                    addr_d  = head[45:6];
                    valid_d = 1'b1;
                end
            end
            PRESENT: begin
                if (pop) begin
                    state_d  = RESP;
                    valid_d  = 1'b0;
                    shared_d = (cpu_ack == 3'd2);
                    owned_d  = (cpu_ack == 3'd3);
                    rvalid_d = 1'b1;
                    rdev_d   = head[5:3];
                    rcid_d   = head[2:0];
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sys_command, sys_address, sys_dev_id, sys_cmd_id};
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            nonempty_q <= 1'b0;
            cmd_q      <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            shared_q   <= 1'b0;
            owned_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rdev_q     <= '0;
            rcid_q     <= '0;
            hold_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            // Lags count by one edge, giving the two-edge present latency
            nonempty_q <= (count_q != '0);
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            shared_q   <= shared_d;
            owned_q    <= owned_d;
            rvalid_q   <= rvalid_d;
            rdev_q     <= rdev_d;
            rcid_q     <= rcid_d;
            hold_q     <= (count_q >= HOLD_C);
            ovf_q      <= ovf_d;
        end
    end

    assign cpu_command   = cmd_q;
    assign cpu_address   = addr_q;
    assign cpu_sys_valid = valid_q;
    assign shared_out    = shared_q;
    assign owned_out     = owned_q;
    assign resp_valid    = rvalid_q;
    assign resp_dev_id   = rdev_q;
    assign resp_cmd_id   = rcid_q;
    assign sys_hold_out  = hold_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_snoop_cmd_queue.sv
// Testbench for snoop_cmd_queue: vector table plus hand-written corner sequences.
// Expected snoop entries are queued when driven and checked when presented.
module tb_snoop_cmd_queue;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [39:0] addr;
        logic [2:0]  dev;
        logic [2:0]  cid;
    } ent_t;

    typedef struct {
        logic [3:0]  cmd;
        logic [39:0] addr;
        logic [2:0]  dev;
        logic [2:0]  cid;
        logic [2:0]  ack;
        bit          q;
        bit          sh;
        bit          ow;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [3:0]  sys_command;
    logic [39:0] sys_address;
    logic [2:0]  sys_dev_id;
    logic [2:0]  sys_cmd_id;
    logic [3:0]  cpu_command;
    logic [39:0] cpu_address;
    logic        cpu_sys_valid;
    logic [2:0]  cpu_ack;
    logic        shared_out;
    logic        owned_out;
    logic        resp_valid;
    logic [2:0]  resp_dev_id;
    logic [2:0]  resp_cmd_id;
    logic        sys_hold_out;
    logic        overflow;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    ent_t exp_q[$];
    vec_t vt[8];

    snoop_cmd_queue dut (
        .CLOCK        (clk),
        .RESET        (rst),
        .sys_command  (sys_command),
        .sys_address  (sys_address),
        .sys_dev_id   (sys_dev_id),
        .sys_cmd_id   (sys_cmd_id),
        .cpu_command  (cpu_command),
        .cpu_address  (cpu_address),
        .cpu_sys_valid(cpu_sys_valid),
        .cpu_ack      (cpu_ack),
        .shared_out   (shared_out),
        .owned_out    (owned_out),
        .resp_valid   (resp_valid),
        .resp_dev_id  (resp_dev_id),
        .resp_cmd_id  (resp_cmd_id),
        .sys_hold_out (sys_hold_out),
        .overflow     (overflow),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input ent_t e);
        sys_command = e.cmd;
        sys_address = e.addr;
        sys_dev_id  = e.dev;
        sys_cmd_id  = e.cid;
    endtask

    task automatic idle_bus();
        sys_command = 4'd0;
        sys_address = 40'd0;
        sys_dev_id  = 3'd0;
        sys_cmd_id  = 3'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_ack = 3'd0;
        idle_bus();
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (!cpu_sys_valid && n < 40) begin
            tick();
            n++;
        end
        ok = cpu_sys_valid;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL present_wait: cpu_sys_valid=0 after %0d cycles want 1", n);
        end
    endtask

    task automatic serve(input logic [2:0] ack, input bit px, input ent_t pe,
                         input bit sh, input bit ow);
        ent_t e;
        bit ok;
        wait_valid(ok);
        if (!ok) return;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got a presentation want none");
            return;
        end
        e = exp_q.pop_front();
        chk("cpu_command", 64'(cpu_command), 64'(e.cmd));
        chk("cpu_address", 64'(cpu_address), 64'(e.addr));
        cpu_ack = ack;
        if (px) begin
            drive(pe);
            exp_q.push_back(pe);
        end
        tick();
        cpu_ack = 3'd0;
        idle_bus();
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("cpu_valid_clr", 64'(cpu_sys_valid), 64'd0);
        chk("resp_so", 64'({shared_out, owned_out}), 64'({sh, ow}));
        chk("resp_ids", 64'({resp_dev_id, resp_cmd_id}), 64'({e.dev, e.cid}));
        tick();
        chk("resp_one_cycle", 64'({resp_valid, shared_out, owned_out}), 64'd0);
    endtask

    initial begin
        ent_t e;
        ent_t z;
        bit ok;
        int n;
        bit seen;

        z = '0;
        rst = 1'b1;
        cpu_ack = 3'd0;
        idle_bus();
        do_reset();
        chk("reset_outs",
            64'({cpu_command, cpu_sys_valid, shared_out, owned_out, resp_valid,
                 resp_dev_id, resp_cmd_id, sys_hold_out, overflow, timeout_err}),
            64'd0);
        chk("reset_addr", 64'(cpu_address), 64'd0);

        // basic: capture, two-edge latency, shared answer
        e = '{4'h2, 40'h12_3456_7800, 3'd3, 3'd5};
        drive(e);
        exp_q.push_back(e);
        tick();
        idle_bus();
        chk("lat_edge0", 64'(cpu_sys_valid), 64'd0);
        tick();
        chk("lat_edge1", 64'(cpu_sys_valid), 64'd0);
        tick();
        chk("lat_edge2", 64'(cpu_sys_valid), 64'd1);
        serve(3'd2, 1'b0, z, 1'b1, 1'b0);

        vt[0] = '{4'h1, 40'h00_0000_0040, 3'd1, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0};
        vt[1] = '{4'h3, 40'hff_ffff_ffc0, 3'd7, 3'd7, 3'd2, 1'b1, 1'b1, 1'b0};
        vt[2] = '{4'hf, 40'h80_0000_0000, 3'd2, 3'd1, 3'd3, 1'b1, 1'b0, 1'b1};
        vt[3] = '{4'h4, 40'h01_2345_6789, 3'd0, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0};
        vt[4] = '{4'h5, 40'h0a_bcde_f000, 3'd4, 3'd6, 3'd5, 1'b1, 1'b0, 1'b0};
        vt[5] = '{4'h0, 40'h33_0000_0000, 3'd3, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0};
        vt[6] = '{4'h6, 40'h00_dead_beef, 3'd5, 3'd3, 3'd7, 1'b1, 1'b0, 1'b0};
        vt[7] = '{4'h2, 40'h7f_0000_1000, 3'd6, 3'd4, 3'd2, 1'b1, 1'b1, 1'b0};

        for (int i = 0; i < 8; i++) begin
            e = '{vt[i].cmd, vt[i].addr, vt[i].dev, vt[i].cid};
            drive(e);
            if (vt[i].q) exp_q.push_back(e);
            tick();
            idle_bus();
            if (vt[i].q) begin
                serve(vt[i].ack, 1'b0, z, vt[i].sh, vt[i].ow);
            end else begin
                cpu_ack = vt[i].ack;
                repeat (4) tick();
                cpu_ack = 3'd0;
                chk("not_queued", 64'({cpu_sys_valid, resp_valid}), 64'd0);
            end
        end

        // fill past full with no ack: hold timing, overflow on the 9th
        for (int i = 0; i < 9; i++) begin
            e = '{4'(i + 1), 40'(64'h1000 * i), 3'((i % 7) + 1), 3'(i)};
            drive(e);
            if (i < 8) exp_q.push_back(e);
            tick();
            if (i == 5) chk("hold_at6_early", 64'(sys_hold_out), 64'd0);
            if (i == 6) chk("hold_at6_late", 64'(sys_hold_out), 64'd1);
            if (i == 7) chk("ovf_at_full", 64'(overflow), 64'd0);
            if (i == 8) chk("ovf_9th", 64'(overflow), 64'd1);
        end
        idle_bus();
        for (int k = 0; k < 8; k++) serve(3'd3, 1'b0, z, 1'b0, 1'b1);
        repeat (4) tick();
        chk("drained", 64'({cpu_sys_valid, sys_hold_out, overflow}), 64'b001);

        // full + present: same-edge ack and push
        do_reset();
        for (int i = 0; i < 8; i++) begin
            e = '{4'h9, 40'(64'h2_0000 + 64'(i) * 64'h40), 3'd2, 3'(i)};
            drive(e);
            exp_q.push_back(e);
            tick();
        end
        idle_bus();
        e = '{4'hc, 40'h55_5555_5500, 3'd5, 3'd7};
        serve(3'd1, 1'b1, e, 1'b0, 1'b0);
        chk("ovf_same_edge", 64'(overflow), 64'd0);
        drive('{4'hd, 40'h66_0000_0000, 3'd4, 3'd1});
        tick();
        idle_bus();
        chk("count_still8", 64'(overflow), 64'd1);
        chk("hold_full", 64'(sys_hold_out), 64'd1);
        for (int k = 0; k < 8; k++) serve(3'd2, 1'b0, z, 1'b1, 1'b0);
        repeat (4) tick();
        chk("no_extra", 64'(cpu_sys_valid), 64'd0);

        // reset mid-handshake drops the snoop
        do_reset();
        drive('{4'h7, 40'h01_0000_0080, 3'd1, 3'd2});
        tick();
        idle_bus();
        wait_valid(ok);
        rst = 1'b1;
        cpu_ack = 3'd2;
        tick();
        chk("rst_mid_outs",
            64'({cpu_command, cpu_sys_valid, shared_out, owned_out, resp_valid,
                 resp_dev_id, resp_cmd_id, sys_hold_out, overflow}),
            64'd0);
        chk("rst_mid_addr", 64'(cpu_address), 64'd0);
        rst = 1'b0;
        cpu_ack = 3'd0;
        tick();
        tick();
        tick();
        chk("rst_mid_after", 64'({cpu_sys_valid, resp_valid}), 64'd0);
        e = '{4'h3, 40'h02_0000_0100, 3'd6, 3'd6};
        drive(e);
        exp_q.push_back(e);
        tick();
        idle_bus();
        serve(3'd3, 1'b0, z, 1'b0, 1'b1);

`ifdef SNOOP_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < 2; i++) begin
            e = '{4'ha, 40'(64'h3_0000 + 64'(i)), 3'd3, 3'(i + 2)};
            drive(e);
            exp_q.push_back(e);
            tick();
        end
        idle_bus();
        wait_valid(ok);
        e = exp_q.pop_front();
        n = 0;
        do begin
            tick();
            n++;
        end while (!resp_valid && n < 200);
        chk("tmo_cycles", 64'(n), 64'd64);
        chk("tmo_resp", 64'({resp_valid, shared_out, owned_out, cpu_sys_valid}), 64'b1000);
        chk("tmo_ids", 64'({resp_dev_id, resp_cmd_id}), 64'({e.dev, e.cid}));
        chk("tmo_err", 64'(timeout_err), 64'd1);
        tick();
        tick();
        chk("tmo_next", 64'(cpu_sys_valid), 64'd1);
        serve(3'd1, 1'b0, z, 1'b0, 1'b0);
`else
        do_reset();
        e = '{4'hb, 40'h04_0000_0000, 3'd7, 3'd1};
        drive(e);
        exp_q.push_back(e);
        tick();
        idle_bus();
        wait_valid(ok);
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (resp_valid) seen = 1'b1;
        end
        chk("no_tmo_wait", 64'({cpu_sys_valid, seen, timeout_err}), 64'b100);
        serve(3'd1, 1'b0, z, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snoop_cmd_queue.md
Name: snoop_cmd_queue

Overview:
- Downstream of the system bus address phase; upstream of the CPU bus snoop interface.
- Captures foreign address-phase commands seen on the system bus and buffers them in a FIFO.
- Presents each command to the CPU with a sys_valid/cpu_ack handshake.
- Returns the CPU's coherence answer on the system bus shared_out/owned_out lines, tagged with the originating dev_id/cmd_id.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- MY_DEV_ID, 0: own device id; commands carrying this dev_id are not queued.
- HOLD_LEVEL, 6: occupancy at or above which sys_hold_out asserts.
- TIMEOUT, 64: cycles to wait for cpu_ack; used only with SNOOP_TIMEOUT_EN.

Ports:
- CLOCK  in  1  single clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- sys_command  in  4  system bus command; 0 = idle.
- sys_address  in  40  system bus address.
- sys_dev_id  in  3  issuing device id.
- sys_cmd_id  in  3  issuing command tag.
- cpu_command  out  4  snoop command presented to the CPU.
- cpu_address  out  40  snoop address presented to the CPU.
- cpu_sys_valid  out  1  snoop presentation valid.
- cpu_ack  in  3  CPU response: 0 none, 1 miss, 2 shared, 3 owned, 4-7 reserved (treated as miss).
- shared_out  out  1  one-cycle shared response to the system bus.
- owned_out  out  1  one-cycle owned response to the system bus.
- resp_valid  out  1  one-cycle response strobe.
- resp_dev_id  out  3  dev_id of the answered command.
- resp_cmd_id  out  3  cmd_id of the answered command.
- sys_hold_out  out  1  throttle request to the system bus.
- overflow  out  1  sticky; a command arrived while the FIFO was full.
- timeout_err  out  1  sticky; CPU ack timeout (SNOOP_TIMEOUT_EN only, otherwise tied 0).

Behaviour:
- Interface decision: one clock, CLOCK; reset RESET is synchronous and active-high.
- Reset: all outputs 0. FIFO empty, pointers and count 0, FSM IDLE, sticky flags cleared.
- Reset mid-handshake drops the in-flight snoop; no response pulse is issued.
- Capture: at each edge, push {command, address, dev_id, cmd_id} when sys_command!=0, sys_dev_id!=MY_DEV_ID and the FIFO is not full.
- Full: if a qualifying command arrives while full and no pop occurs that cycle, drop it and set overflow.
- Full with same-cycle pop: the push is accepted and count is unchanged.
- Count: width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- sys_hold_out = registered (count >= HOLD_LEVEL); updates one cycle after count.
- FSM states: IDLE, PRESENT, RESP.
- IDLE -> PRESENT when the FIFO is non-empty.
  - Load the head into the cpu_* output registers and set cpu_sys_valid=1.
  - Latency: a command captured at edge N into an empty FIFO with the FSM in IDLE gives cpu_sys_valid high after edge N+2.
- PRESENT:
  - Hold cpu_sys_valid, cpu_command and cpu_address stable until cpu_ack!=0 is sampled.
  - On that edge: pop the FIFO, clear cpu_sys_valid, go to RESP.
  - Register outputs for the RESP cycle: shared_out = (ack==2), owned_out = (ack==3), resp_valid=1, resp_dev_id/resp_cmd_id from the entry.
- RESP: the response outputs are high for exactly one cycle, then clear; go to IDLE.
  - A back-to-back entry is re-presented at the earliest 2 edges after the ack edge.
- cpu_ack sampled in IDLE or RESP is ignored.
- FIFO ordering is strict; no address merging.

Optional Feature:
- Macro: SNOOP_TIMEOUT_EN.
- Defined:
  - A counter runs in PRESENT. Reaching TIMEOUT cycles without an ack forces a miss response (shared_out=owned_out=0, resp_valid=1).
  - The entry is popped and timeout_err is set.
  - The counter clears on entering PRESENT.
- Undefined: no counter; PRESENT waits indefinitely; timeout_err tied 0.

Test Plan:
- Reset, then sys_command=4'h2, address 40'h12_3456_7800, dev_id=3, cmd_id=5 for one cycle -> cpu_sys_valid high 2 edges later with cpu_command=2 and the same address; cpu_ack=2 -> next cycle shared_out=1, resp_valid=1, resp_dev_id=3, resp_cmd_id=5, for one cycle only.
- Command with dev_id=MY_DEV_ID=0 -> never queued; cpu_sys_valid stays 0.
- Hold cpu_ack=0; push 9 foreign commands with DEPTH=8 -> overflow=1 after the 9th; sys_hold_out=1 one cycle after count reaches 6. Then ack 8 times with cpu_ack=3 -> 8 owned_out pulses in push order, first 8 cmd_ids.
- FIFO full and PRESENT: ack and a new push on the same edge -> push accepted, overflow stays 0, count stays 8.
- Assert RESET while cpu_sys_valid=1 -> next cycle all outputs 0, no resp_valid; a new command after reset is presented normally.
- SNOOP_TIMEOUT_EN, TIMEOUT=64: never ack -> after 64 cycles in PRESENT, resp_valid=1 with shared_out=owned_out=0, timeout_err=1, and the next entry is presented.
